// File: rtl/hermitian_frame_builder.sv
// Packs half-frames of complex symbols into Hermitian-symmetric NFFT-point frames via a ping-pong buffer.
// Optional macro HFB_DC_NULL_EN forces bins 0 and NFFT/2 to zero (DC/Nyquist null).
// Handshake: a transfer happens on a rising edge where valid && ready; valid holds its payload until then.
module hermitian_frame_builder #(
    parameter int DW   = 8,
    parameter int NFFT = 128
) (
    input  logic          wrclock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_real,
    input  logic [DW-1:0] in_imag,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_real,
    output logic [DW-1:0] out_imag,
    output logic          out_sop,
    output logic          out_eop,
    output logic [15:0]   frames_out
);

    localparam int HALF = NFFT / 2;
    localparam int HW   = $clog2(HALF);
    localparam int KW   = HW + 1;

    typedef enum logic {S_IDLE, S_STREAM} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [2*DW-1:0] r_mem [0:NFFT-1];
    logic [1:0]      r_full;
    logic [1:0]      w_full_nxt;
    logic [HW:0]     r_fill [0:1];
    logic            r_wr_bank;
    logic            r_rd_bank;
    logic [HW-1:0]   r_wr_idx;
    logic [KW-1:0]   r_k;
    logic            r_in_ready;
    logic [15:0]     r_frames;

    logic            w_wr_fire;
    logic            w_wr_done;
    logic            w_wr_bank_nxt;
    logic            w_rd_fire;
    logic            w_rd_done;
    logic [HW-1:0]   w_idx;
    logic            w_zero;
    logic [2*DW-1:0] w_word;
    logic [DW-1:0]   w_xr;
    logic [DW-1:0]   w_xi;
    logic [DW-1:0]   w_xi_neg;
    logic [DW-1:0]   w_re;
    logic [DW-1:0]   w_im;

    assign w_wr_fire     = in_valid && r_in_ready;
    assign w_wr_done     = w_wr_fire && ((r_wr_idx == HW'(HALF - 1)) || in_last);
    assign w_wr_bank_nxt = w_wr_done ? ~r_wr_bank : r_wr_bank;
    assign w_rd_fire     = out_valid && out_ready;
    assign w_rd_done     = w_rd_fire && (r_k == KW'(NFFT - 1));

    // Write and release always hit different banks, so both updates apply together.
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_done) w_full_nxt[r_wr_bank] = 1'b1;
        if (w_rd_done) w_full_nxt[r_rd_bank] = 1'b0;
    end

    always_ff @(posedge wrclock) begin
        if (w_wr_fire) r_mem[{r_wr_bank, r_wr_idx}] <= {in_real, in_imag};
    end

    always_ff @(posedge wrclock or negedge reset) begin
        if (!reset) begin
            r_full     <= '0;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_wr_idx   <= '0;
            r_k        <= '0;
            r_in_ready <= 1'b0;
            r_frames   <= '0;
            for (int i = 0; i < 2; i++) r_fill[i] <= '0;
        end else begin
            r_full     <= w_full_nxt;
            r_in_ready <= ~w_full_nxt[w_wr_bank_nxt];
            if (w_wr_fire) begin
                if (w_wr_done) begin
                    r_fill[r_wr_bank] <= {1'b0, r_wr_idx} + (HW + 1)'(1);
                    r_wr_bank         <= ~r_wr_bank;
                    r_wr_idx          <= '0;
                end else begin
                    r_wr_idx <= r_wr_idx + HW'(1);
                end
            end
            if (w_rd_fire) r_k <= r_k + KW'(1);
            if (w_rd_done) begin
                r_rd_bank <= ~r_rd_bank;
                r_frames  <= r_frames + 16'd1;
            end
        end
    end

    always_ff @(posedge wrclock or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // In IDLE nothing is full, so the write bank is the read bank: a closing write starts streaming.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (r_full[r_rd_bank] || w_wr_done) w_state_nxt = S_STREAM;
            S_STREAM: if (w_rd_done && !w_full_nxt[~r_rd_bank]) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Upper half mirrors: index NFFT-k, which wraps to 0 at k = NFFT/2.
    assign w_idx    = r_k[HW] ? (HW'(0) - r_k[HW-1:0]) : r_k[HW-1:0];
    assign w_zero   = ({1'b0, w_idx} >= r_fill[r_rd_bank]);
    assign w_word   = r_mem[{r_rd_bank, w_idx}];
    assign w_xr     = w_zero ? '0 : w_word[2*DW-1:DW];
    assign w_xi     = w_zero ? '0 : w_word[DW-1:0];
    assign w_xi_neg = (w_xi == {1'b1, {(DW-1){1'b0}}}) ? {1'b0, {(DW-1){1'b1}}} : (DW'(0) - w_xi);

    always_comb begin
        w_re = '0;
        w_im = '0;
        if (r_k == '0) begin
            w_re = w_xr;
        end else if (r_k == KW'(HALF)) begin
            w_re = w_xi;
        end else if (!r_k[HW]) begin
            w_re = w_xr;
            w_im = w_xi;
        end else begin
            w_re = w_xr;
            w_im = w_xi_neg;
        end
`ifdef HFB_DC_NULL_EN
        if (r_k[HW-1:0] == '0) begin
            w_re = '0;
            w_im = '0;
        end
`else
`endif
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = (r_state == S_STREAM);
    assign out_real   = out_valid ? w_re : '0;
    assign out_imag   = out_valid ? w_im : '0;
    assign out_sop    = out_valid && (r_k == '0);
    assign out_eop    = out_valid && (r_k == KW'(NFFT - 1));
    assign frames_out = r_frames;

endmodule

// File: tb/tb_hermitian_frame_builder.sv
// Directed bench for hermitian_frame_builder at NFFT=16, DW=8; expected bins come from a spec-level model.
module tb_hermitian_frame_builder;

    localparam int DW   = 8;
    localparam int NFFT = 16;
    localparam int HALF = 8;

    logic          wrclock   = 1'b0;
    logic          reset     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_last   = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_real   = '0;
    logic [DW-1:0] in_imag   = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_real;
    logic [DW-1:0] out_imag;
    logic          out_sop;
    logic          out_eop;
    logic [15:0]   frames_out;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [2*DW-1:0] exp_q[$];
    logic [DW-1:0]   x_re [0:HALF-1];
    logic [DW-1:0]   x_im [0:HALF-1];
    int              x_fill;
    logic [DW-1:0]   got_re  [0:2*NFFT-1];
    logic [DW-1:0]   got_im  [0:2*NFFT-1];
    logic            got_sop [0:2*NFFT-1];
    logic            got_eop [0:2*NFFT-1];
    int              got_cyc [0:2*NFFT-1];

    always #5 wrclock = ~wrclock;
    always @(posedge wrclock) cyc <= cyc + 1;

    hermitian_frame_builder #(.DW(DW), .NFFT(NFFT)) dut (
        .wrclock    (wrclock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_real    (in_real),
        .in_imag    (in_imag),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_real   (out_real),
        .out_imag   (out_imag),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .frames_out (frames_out)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] neg_sat(input logic [DW-1:0] v);
        if (v == 8'h80) return 8'h7F;
        return 8'h00 - v;
    endfunction

    // Expected frame straight from the bin-mapping definition.
    task automatic push_model();
        logic [DW-1:0] xr, xi, re, im;
        int i;
        for (int k = 0; k < NFFT; k++) begin
            if (k == 0 || k == HALF) i = 0;
            else if (k < HALF)       i = k;
            else                     i = NFFT - k;
            xr = (i < x_fill) ? x_re[i] : 8'h00;
            xi = (i < x_fill) ? x_im[i] : 8'h00;
            if (k == 0)         begin re = xr; im = 8'h00; end
            else if (k == HALF) begin re = xi; im = 8'h00; end
            else if (k < HALF)  begin re = xr; im = xi; end
            else                begin re = xr; im = neg_sat(xi); end
`ifdef HFB_DC_NULL_EN
            if (k == 0 || k == HALF) begin re = 8'h00; im = 8'h00; end
`endif
            exp_q.push_back({re, im});
        end
    endtask

    // Starts and ends at 1 time unit after a rising edge.
    task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im, input logic last);
        int budget;
        budget   = 200;
        in_valid = 1'b1;
        in_real  = re;
        in_imag  = im;
        in_last  = last;
        while (budget > 0) begin
            @(negedge wrclock);
            if (in_ready) begin
                @(posedge wrclock);
                #1;
                break;
            end
            @(posedge wrclock);
            #1;
            budget--;
        end
        if (budget == 0) begin
            n_vec++;
            n_fail++;
            $error("FAIL send_timeout: observed no in_ready, required in_ready=1");
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic load_half(input int n);
        x_fill = n;
        for (int i = 0; i < n; i++) send(x_re[i], x_im[i], (i == n - 1) && (n < HALF));
    endtask

    task automatic collect(input int nxfer, input bit toggle);
        int            budget, n_got;
        bit            have_hold, ph;
        logic [15:0]   held, expv;
        budget    = nxfer * 4 + 20;
        n_got     = 0;
        have_hold = 1'b0;
        ph        = 1'b0;
        while (n_got < nxfer && budget > 0) begin
            out_ready = toggle ? ph : 1'b1;
            ph        = ~ph;
            @(negedge wrclock);
            if (have_hold) begin
                chk("hold_valid", 16'(out_valid), 16'd1);
                chk("hold_value", {out_real, out_imag}, held);
            end
            have_hold = 1'b0;
            if (out_valid && out_ready) begin
                got_re[n_got]  = out_real;
                got_im[n_got]  = out_imag;
                got_sop[n_got] = out_sop;
                got_eop[n_got] = out_eop;
                got_cyc[n_got] = cyc;
                if (exp_q.size() == 0) expv = 16'hxxxx;
                else                   expv = exp_q.pop_front();
                chk($sformatf("bin%0d", n_got % NFFT), {out_real, out_imag}, expv);
                chk("sop", 16'(out_sop), 16'((n_got % NFFT) == 0));
                chk("eop", 16'(out_eop), 16'((n_got % NFFT) == NFFT - 1));
                n_got++;
            end else if (out_valid) begin
                have_hold = 1'b1;
                held      = {out_real, out_imag};
            end
            @(posedge wrclock);
            #1;
            budget--;
        end
        out_ready = 1'b0;
        if (n_got < nxfer) begin
            n_vec++;
            n_fail++;
            $error("FAIL collect_timeout: observed %0d transfers, required %0d", n_got, nxfer);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge wrclock);
        #1;
        @(negedge wrclock);
        chk("rst_in_ready", 16'(in_ready), 16'd0);
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        chk("rst_sop_eop", 16'({out_sop, out_eop}), 16'd0);
        chk("rst_data", {out_real, out_imag}, 16'h0000);
        chk("rst_frames", frames_out, 16'd0);
        @(posedge wrclock);
        #1;
        reset = 1'b1;
        @(posedge wrclock);
        #1;
        @(negedge wrclock);
        chk("rel_in_ready", 16'(in_ready), 16'd1);
        @(posedge wrclock);
        #1;

        // Full half-frame (i, -i)
        for (int i = 0; i < HALF; i++) begin
            x_re[i] = 8'(i);
            x_im[i] = 8'(-i);
        end
        load_half(HALF);
        chk("latency1", 16'(out_valid), 16'd1);
        push_model();
        collect(NFFT, 1'b0);
        chk("t1_bin0", {got_re[0], got_im[0]}, 16'h0000);
        chk("t1_bin3", {got_re[3], got_im[3]}, 16'h03FD);
        chk("t1_bin8", {got_re[8], got_im[8]}, 16'h0000);
        chk("t1_bin13", {got_re[13], got_im[13]}, 16'h0303);
        chk("t1_sop0", 16'(got_sop[0]), 16'd1);
        chk("t1_eop15", 16'(got_eop[15]), 16'd1);
        chk("t1_frames", frames_out, 16'd1);

        // Short frame closed by in_last
        x_re[0] = 8'd5; x_im[0] = 8'd7;
        x_re[1] = 8'd1; x_im[1] = 8'd2;
        x_re[2] = 8'd3; x_im[2] = 8'd4;
        for (int i = 3; i < HALF; i++) begin
            x_re[i] = 8'hEE;
            x_im[i] = 8'hEE;
        end
        load_half(3);
        push_model();
        collect(NFFT, 1'b0);
`ifdef HFB_DC_NULL_EN
        chk("t2_bin0", {got_re[0], got_im[0]}, 16'h0000);
        chk("t2_bin8", {got_re[8], got_im[8]}, 16'h0000);
`else
        chk("t2_bin0", {got_re[0], got_im[0]}, 16'h0500);
        chk("t2_bin8", {got_re[8], got_im[8]}, 16'h0700);
`endif
        chk("t2_bin2", {got_re[2], got_im[2]}, 16'h0304);
        chk("t2_bin14", {got_re[14], got_im[14]}, 16'h03FC);
        for (int k = 3; k <= 13; k++) begin
            if (k != HALF) chk($sformatf("t2_zero%0d", k), {got_re[k], got_im[k]}, 16'h0000);
        end
        chk("t2_frames", frames_out, 16'd2);

        // Both banks filled under backpressure, then drained back to back
        for (int i = 0; i < HALF; i++) begin
            x_re[i] = 8'(8'h10 + i);
            x_im[i] = 8'(8'h20 + i);
        end
        load_half(HALF);
        push_model();
        for (int i = 0; i < HALF; i++) begin
            x_re[i] = 8'($urandom_range(0, 255));
            x_im[i] = 8'($urandom_range(0, 255));
        end
        load_half(HALF);
        push_model();
        @(negedge wrclock);
        chk("bp_in_ready_low", 16'(in_ready), 16'd0);
        chk("bp_out_valid", 16'(out_valid), 16'd1);
        @(posedge wrclock);
        #1;
        @(negedge wrclock);
        chk("bp_in_ready_held", 16'(in_ready), 16'd0);
        @(posedge wrclock);
        #1;
        collect(2 * NFFT, 1'b0);
        chk("b2b_gap", 16'(got_cyc[NFFT] - got_cyc[NFFT-1]), 16'd1);
        chk("b2b_eop", 16'(got_eop[NFFT-1]), 16'd1);
        chk("b2b_sop", 16'(got_sop[NFFT]), 16'd1);
        chk("bp_frames", frames_out, 16'd4);
        chk("bp_in_ready_back", 16'(in_ready), 16'd1);

        // Stall every other cycle; -128 imag at index 2 saturates in bin 14
        for (int i = 0; i < HALF; i++) begin
            x_re[i] = 8'(i * 3 + 1);
            x_im[i] = 8'(8'h40 - i);
        end
        x_im[2] = 8'h80;
        load_half(HALF);
        push_model();
        collect(NFFT, 1'b1);
        chk("sat_bin14", {got_re[14], got_im[14]}, 16'h077F);
        chk("sat_bin2", {got_re[2], got_im[2]}, 16'h0780);
        chk("stall_frames", frames_out, 16'd5);

        // Reset while bin 6 is presented
        load_half(HALF);
        push_model();
        collect(6, 1'b0);
        exp_q.delete();
        @(negedge wrclock);
        chk("mid_valid_before", 16'(out_valid), 16'd1);
        @(posedge wrclock);
        #1;
        reset = 1'b0;
        #1;
        @(negedge wrclock);
        chk("mid_out_valid", 16'(out_valid), 16'd0);
        chk("mid_frames", frames_out, 16'd0);
        chk("mid_in_ready", 16'(in_ready), 16'd0);
        chk("mid_data", {out_real, out_imag}, 16'h0000);
        @(posedge wrclock);
        #1;
        reset = 1'b1;
        @(posedge wrclock);
        #1;
        @(negedge wrclock);
        chk("post_in_ready", 16'(in_ready), 16'd1);
        chk("post_out_valid", 16'(out_valid), 16'd0);
        @(posedge wrclock);
        #1;

        // Single-symbol frame after reset
        x_re[0] = 8'h9C;
        x_im[0] = 8'h80;
        load_half(1);
        push_model();
        collect(NFFT, 1'b0);
        chk("one_bin1", {got_re[1], got_im[1]}, 16'h0000);
        chk("one_frames", frames_out, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
